// File: rtl/cache_arbiter_if.sv
// Bundles the I-cache, D-cache and physical-memory sides of the cache arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and memory.
interface cache_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) ();
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between I- and D-cache; grant one cycle after request.
// Granted requester holds until pmem_resp, which is passed through the same cycle; an IDLE cycle separates grants.
module cache_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic            clk,
    input  logic            reset,
    cache_arbiter_if.slave  bus,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t state;
    logic   last_grant;     // 0 = I served last, 1 = D served last
    logic   i_req;
    logic   d_req;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // On a conflict the side that was not served last wins.
                    if (i_req && d_req) begin
                        state <= last_grant ? GRANT_I : GRANT_D;
                        busy  <= 1'b1;
                    end else if (i_req) begin
                        state <= GRANT_I;
                        busy  <= 1'b1;
                    end else if (d_req) begin
                        state <= GRANT_D;
                        busy  <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (bus.pmem_resp) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (bus.pmem_resp) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = {ADDR_W{1'b0}};
        bus.pmem_wdata   = {LINE_W{1'b0}};
        bus.i_resp       = 1'b0;
        bus.d_resp       = 1'b0;
        case (state)
            GRANT_I: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = bus.i_address;
                bus.i_resp       = bus.pmem_resp;
            end
            GRANT_D: begin
                // Simultaneous read and write from the D-cache is a write-back.
                bus.pmem_read    = bus.d_read & ~bus.d_write;
                bus.pmem_write   = bus.d_write;
                bus.pmem_address = bus.d_address;
                bus.pmem_wdata   = bus.d_wdata;
                bus.d_resp       = bus.pmem_resp;
            end
            default: ;
        endcase
    end

    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed vector table for the cache arbiter plus a continuous-conflict fairness sequence.
module tb_cache_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic clk;
    logic reset;
    logic busy;

    cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ir;
        bit          dr;
        bit          dw;
        bit          pr;
        logic [15:0] ia;
        logic [15:0] da;
        bit          e_pread;
        bit          e_pwrite;
        logic [15:0] e_paddr;
        bit          e_wd;
        bit          e_iresp;
        bit          e_dresp;
        bit          e_busy;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = 0;

    logic [LINE_W-1:0] rd_pat;
    logic [LINE_W-1:0] wd_pat;
    logic [LINE_W-1:0] zero_line;

    function automatic vec_t mk(bit rst, bit ir, bit dr, bit dw, bit pr,
                                logic [15:0] ia, logic [15:0] da,
                                bit epr, bit epw, logic [15:0] ea, bit ewd,
                                bit eir, bit edr, bit eb);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.pr = pr;
        v.ia = ia; v.da = da;
        v.e_pread = epr; v.e_pwrite = epw; v.e_paddr = ea; v.e_wd = ewd;
        v.e_iresp = eir; v.e_dresp = edr; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d actual %h required %h", name, row, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rd_pat    = {16{8'hA5}};
        wd_pat    = {16{8'h0F}};
        zero_line = '0;

        reset         = 1'b1;
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = wd_pat;
        bus.pmem_rdata = rd_pat;
        bus.pmem_resp = 1'b0;

        //               rst ir dr dw pr  ia        da        | prd pwr paddr     wd ir dr busy
        vq.push_back(mk(1, 0, 0, 0, 0, 16'h1230, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0));
        // I-cache line fill, memory answers on the fourth granted cycle
        vq.push_back(mk(0, 1, 0, 0, 0, 16'h1230, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 16'h1230, 16'h0000, 1, 0, 16'h1230, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 16'h1230, 16'h0000, 1, 0, 16'h1230, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 16'h1230, 16'h0000, 1, 0, 16'h1230, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 1, 16'h1230, 16'h0000, 1, 0, 16'h1230, 0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 16'h1230, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0));
        // D-cache write-back
        vq.push_back(mk(0, 0, 0, 1, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 16'h1230, 16'h4000, 0, 1, 16'h4000, 1, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 1, 1, 16'h1230, 16'h4000, 0, 1, 16'h4000, 1, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        // stray memory responses while idle
        vq.push_back(mk(0, 0, 0, 0, 1, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        // conflicts after reset: D, then I, then D
        vq.push_back(mk(1, 0, 0, 0, 0, 16'h1230, 16'h2000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 0, 16'h1230, 16'h2000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 0, 16'h1230, 16'h2000, 1, 0, 16'h2000, 1, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 0, 1, 16'h1230, 16'h2000, 1, 0, 16'h2000, 1, 0, 1, 1));
        vq.push_back(mk(0, 1, 1, 0, 0, 16'h1230, 16'h2000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 1, 16'h1230, 16'h2000, 1, 0, 16'h1230, 0, 1, 0, 1));
        vq.push_back(mk(0, 1, 1, 0, 0, 16'h1230, 16'h2000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 1, 16'h1230, 16'h2000, 1, 0, 16'h2000, 1, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 16'h1230, 16'h2000, 0, 0, 16'h0000, 0, 0, 0, 0));
        // reset during a write-back grant, late response ignored, then re-grant
        vq.push_back(mk(0, 0, 0, 1, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 16'h1230, 16'h4000, 0, 1, 16'h4000, 1, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 1, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 1, 16'h1230, 16'h4000, 0, 1, 16'h4000, 1, 0, 1, 1));
        // request dropped mid-grant keeps the grant until the response
        vq.push_back(mk(0, 1, 0, 0, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 16'h1230, 16'h4000, 1, 0, 16'h1230, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 16'h1230, 16'h4000, 1, 0, 16'h1230, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1, 16'h1230, 16'h4000, 1, 0, 16'h1230, 0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        // read and write together behave as a write
        vq.push_back(mk(0, 0, 1, 1, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 1, 16'h1230, 16'h4000, 0, 1, 16'h4000, 1, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 16'h1230, 16'h4000, 0, 0, 16'h0000, 0, 0, 0, 0));

        foreach (vq[k]) begin
            @(negedge clk);
            row           = k;
            reset         = vq[k].rst;
            bus.i_read    = vq[k].ir;
            bus.d_read    = vq[k].dr;
            bus.d_write   = vq[k].dw;
            bus.pmem_resp = vq[k].pr;
            bus.i_address = vq[k].ia;
            bus.d_address = vq[k].da;
            #1;
            chk("pmem_read",    LINE_W'(bus.pmem_read),    LINE_W'(vq[k].e_pread));
            chk("pmem_write",   LINE_W'(bus.pmem_write),   LINE_W'(vq[k].e_pwrite));
            chk("pmem_address", LINE_W'(bus.pmem_address), LINE_W'(vq[k].e_paddr));
            chk("pmem_wdata",   bus.pmem_wdata, vq[k].e_wd ? wd_pat : zero_line);
            chk("i_resp",       LINE_W'(bus.i_resp),       LINE_W'(vq[k].e_iresp));
            chk("d_resp",       LINE_W'(bus.d_resp),       LINE_W'(vq[k].e_dresp));
            chk("busy",         LINE_W'(busy),             LINE_W'(vq[k].e_busy));
            chk("i_rdata",      bus.i_rdata, rd_pat);
            chk("d_rdata",      bus.d_rdata, rd_pat);
        end

        // Both sides request continuously; grants must alternate starting with D.
        begin
            bit exp_d;
            bit got_d;
            @(negedge clk);
            row           = 1000;
            reset         = 1'b1;
            bus.i_read    = 1'b0;
            bus.d_read    = 1'b0;
            bus.d_write   = 1'b0;
            bus.pmem_resp = 1'b0;
            @(negedge clk);
            reset         = 1'b0;
            bus.i_read    = 1'b1;
            bus.d_read    = 1'b1;
            bus.i_address = 16'h1230;
            bus.d_address = 16'h2000;
            exp_d = 1'b1;
            for (int t = 0; t < 6; t++) begin
                int waited;
                waited = 0;
                row = 1000 + t;
                @(negedge clk); #1;
                while (!busy && waited < 20) begin
                    @(negedge clk); #1;
                    waited++;
                end
                checks++;
                if (!busy) begin
                    errors++;
                    $display("FAIL grant_timeout row %0d actual busy 0 required busy 1", row);
                end else begin
                    got_d = (bus.pmem_address == 16'h2000);
                    chk("rr_order", LINE_W'(got_d), LINE_W'(exp_d));
                end
                repeat (t % 3) @(negedge clk);
                bus.pmem_resp = 1'b1;
                @(negedge clk);
                bus.pmem_resp = 1'b0;
                #1;
                chk("idle_gap_busy", LINE_W'(busy), LINE_W'(1'b0));
                exp_d = ~exp_d;
            end
            bus.i_read = 1'b0;
            bus.d_read = 1'b0;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, physical address width (lc3b_word).
REQ-002 Parameter LINE_W, default 128, cache line width in bits.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_read  input  1  I-cache line-fill request.
REQ-006 i_address  input  ADDR_W  I-cache line address.
REQ-007 i_rdata  output  LINE_W  line returned to I-cache.
REQ-008 i_resp  output  1  I-cache transaction complete.
REQ-009 d_read  input  1  D-cache line-fill request.
REQ-010 d_write  input  1  D-cache write-back request.
REQ-011 d_address  input  ADDR_W  D-cache line address.
REQ-012 d_wdata  input  LINE_W  D-cache write-back line.
REQ-013 d_rdata  output  LINE_W  line returned to D-cache.
REQ-014 d_resp  output  1  D-cache transaction complete.
REQ-015 pmem_read  output  1  physical memory read strobe.
REQ-016 pmem_write  output  1  physical memory write strobe.
REQ-017 pmem_address  output  ADDR_W  physical memory address.
REQ-018 pmem_wdata  output  LINE_W  physical memory write line.
REQ-019 pmem_rdata  input  LINE_W  physical memory read line.
REQ-020 pmem_resp  input  1  physical memory transaction complete.
REQ-021 busy  output  1  high whenever a grant is active.

Function
REQ-022 FSM SHALL have exactly three states: IDLE, GRANT_I, GRANT_D; plus 1-bit register last_grant (0=I, 1=D).
REQ-023 IDLE: no requests -> stay IDLE; only i_read -> GRANT_I; only d_read|d_write -> GRANT_D.
REQ-024 IDLE with both I and D requesting SHALL grant the requester not equal to last_grant (round-robin); after reset D wins the first conflict.
REQ-025 Grant latency: request visible in IDLE at cycle N -> grant state and pmem strobe asserted at cycle N+1.
REQ-026 GRANT_I: pmem_read=1, pmem_write=0, pmem_address=i_address, pmem_wdata=0, all combinational from current inputs.
REQ-027 GRANT_D: pmem_read=d_read&~d_write, pmem_write=d_write, pmem_address=d_address, pmem_wdata=d_wdata; d_read and d_write both high SHALL be treated as a write.
REQ-028 IDLE: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0.
REQ-029 i_rdata and d_rdata SHALL both equal pmem_rdata at all times; only resp is steered.
REQ-030 In GRANT_x, x_resp SHALL equal pmem_resp combinationally (same cycle); the other resp SHALL be 0.
REQ-031 GRANT_x with pmem_resp=1 -> next state IDLE and last_grant<=x on that edge; otherwise remain in GRANT_x.
REQ-032 Requesters hold request/address/data until their resp; request deassertion during a grant SHALL NOT abort it -- arbiter stays granted until pmem_resp.
REQ-033 pmem_resp while in IDLE SHALL be ignored (no resp output, no state change).
REQ-034 Every transaction SHALL pass through at least one IDLE cycle; back-to-back grants are never issued without it.
REQ-035 busy SHALL be 1 in GRANT_I/GRANT_D, 0 in IDLE.
REQ-036 A requester continuously requesting SHALL be granted within one transaction of the other requester (no starvation).

Reset
REQ-037 reset=1 SHALL immediately (asynchronously) force state=IDLE, last_grant=0; all outputs then take IDLE values (resp=0, busy=0, strobes=0).
REQ-038 Reset asserted mid-grant SHALL abandon the transaction; a subsequent pmem_resp in IDLE is ignored per REQ-033.

Verification
REQ-039 I only: i_read=1, i_address=0x1230, pmem_resp after 3 cycles with pmem_rdata=0xA5..A5 -> pmem_read=1 addr 0x1230 from cycle 1, i_resp=1 with i_rdata=0xA5..A5 in resp cycle, d_resp=0, IDLE next.
REQ-040 D write-back: d_write=1, d_address=0x4000, d_wdata=0x0F..0F -> pmem_write=1, pmem_read=0, pmem_wdata=0x0F..0F until pmem_resp, d_resp=1 same cycle.
REQ-041 Conflict after reset: i_read and d_read rise same cycle, both held -> D granted first, then IDLE, then I granted; second conflict after that grants I... then D alternately.
REQ-042 Spurious pmem_resp pulses in IDLE -> i_resp=d_resp=0, busy=0, state unchanged.
REQ-043 reset pulsed during GRANT_D before pmem_resp -> pmem_write drops same cycle, busy=0, later pmem_resp produces no d_resp; next d_write re-granted normally.
